// File: rtl/prng_share_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : prng_share_ctrl
// Brief    : Shared Galois LFSR with seed sanitising, fixed warm-up and
//            round-robin delivery of one random word per cycle.
// Revision : 1.0
// ============================================================================
module prng_share_ctrl #(
    parameter int                WIDTH  = 64,
    parameter int                NREQ   = 4,
    parameter logic [WIDTH-1:0]  TAPS   = 64'hD800_0000_0000_0000,
    parameter int                WARMUP = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              seed_load,
    input  logic [WIDTH-1:0]  seed_in,
    input  logic [NREQ-1:0]   req,
    output logic [NREQ-1:0]   grant,
    output logic              rnd_valid,
    output logic [WIDTH-1:0]  rnd_data,
    output logic              ready,
    output logic [15:0]       served_cnt
);

    localparam int              PW        = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam logic [1:0]      S_IDLE    = 2'd0;
    localparam logic [1:0]      S_WARM    = 2'd1;
    localparam logic [1:0]      S_SERVE   = 2'd2;
    localparam logic [7:0]      WARM_LAST = 8'(WARMUP - 1);
    localparam logic [PW-1:0]   PTR_LAST  = PW'(NREQ - 1);
    localparam logic [NREQ-1:0] GRANT_ONE = NREQ'(1);

    logic [1:0]       r_state;
    logic [WIDTH-1:0] r_lfsr;
    logic [PW-1:0]    r_ptr;
    logic [7:0]       r_warm_cnt;

    logic [WIDTH-1:0] w_lfsr_next;
    logic [WIDTH-1:0] w_seed;
    logic [NREQ-1:0]  w_eligible;
    logic             w_found;
    logic [PW-1:0]    w_pick;
    logic [PW-1:0]    w_ptr_next;

    assign w_lfsr_next = {1'b0, r_lfsr[WIDTH-1:1]} ^ (r_lfsr[0] ? TAPS : '0);
    assign w_seed      = (seed_in == '0) ? {{(WIDTH-1){1'b0}}, 1'b1} : seed_in;
    // The requester granted last cycle still shows req; mask it out.
    assign w_eligible  = req & ~grant;
    assign w_ptr_next  = (w_pick == PTR_LAST) ? '0 : w_pick + PW'(1);
    assign ready       = (r_state == S_SERVE);

    // Lowest eligible index overall, overridden by the lowest at or after ptr.
    always_comb begin
        w_found = 1'b0;
        w_pick  = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (w_eligible[i]) begin
                w_found = 1'b1;
                w_pick  = PW'(i);
            end
        end
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (w_eligible[i] && (PW'(i) >= r_ptr)) begin
                w_pick = PW'(i);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_lfsr     <= '0;
            r_ptr      <= '0;
            r_warm_cnt <= '0;
            grant      <= '0;
            rnd_valid  <= 1'b0;
            rnd_data   <= '0;
            served_cnt <= '0;
        end else begin
            grant     <= '0;
            rnd_valid <= 1'b0;
            if (seed_load) begin
                r_state    <= S_WARM;
                r_lfsr     <= w_seed;
                r_warm_cnt <= '0;
                served_cnt <= '0;
            end else begin
                case (r_state)
                    S_WARM: begin
                        r_lfsr     <= w_lfsr_next;
                        r_warm_cnt <= r_warm_cnt + 8'd1;
                        if (r_warm_cnt == WARM_LAST) begin
                            r_state <= S_SERVE;
                        end
                    end
                    S_SERVE: begin
                        if (w_found) begin
                            grant      <= GRANT_ONE << w_pick;
                            rnd_valid  <= 1'b1;
                            rnd_data   <= r_lfsr;
                            r_lfsr     <= w_lfsr_next;
                            r_ptr      <= w_ptr_next;
                            served_cnt <= served_cnt + 16'd1;
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_prng_share_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_prng_share_ctrl
// Brief    : Scoreboard bench for prng_share_ctrl with directed vectors.
// Revision : 1.0
// ============================================================================
module tb_prng_share_ctrl;

    typedef struct {
        logic [3:0]  g;
        logic [63:0] d;
    } exp_t;

    logic        clk;
    logic        reset;
    logic        seed_load;
    logic [63:0] seed_in;
    logic [3:0]  req;
    logic [3:0]  grant;
    logic        rnd_valid;
    logic [63:0] rnd_data;
    logic        ready;
    logic [15:0] served_cnt;

    int   n_tests = 0;
    int   n_fail  = 0;
    exp_t sb[$];

    prng_share_ctrl #(
        .WIDTH  (64),
        .NREQ   (4),
        .TAPS   (64'hD800_0000_0000_0000),
        .WARMUP (8)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .seed_load  (seed_load),
        .seed_in    (seed_in),
        .req        (req),
        .grant      (grant),
        .rnd_valid  (rnd_valid),
        .rnd_data   (rnd_data),
        .ready      (ready),
        .served_cnt (served_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [3:0] g, input logic [63:0] d);
        exp_t e;
        e.g = g;
        e.d = d;
        sb.push_back(e);
    endtask

    // Monitor: pops one expected word whenever the DUT presents a grant.
    always @(negedge clk) begin
        check("valid_vs_grant", 64'(rnd_valid), 64'(grant != 4'b0000));
        if (rnd_valid) begin
            if (sb.size() == 0) begin
                check("unexpected_grant", 64'(grant), 64'h0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("sb_grant", 64'(grant), 64'(e.g));
                check("sb_data", rnd_data, e.d);
            end
        end
    end

    initial begin
        reset     = 1'b1;
        seed_load = 1'b0;
        seed_in   = 64'h0;
        req       = 4'b1111;
        tick();
        tick();
        check("rst_grant", 64'(grant), 64'h0);
        check("rst_valid", 64'(rnd_valid), 64'h0);
        check("rst_data", rnd_data, 64'h0);
        check("rst_ready", 64'(ready), 64'h0);
        check("rst_served", 64'(served_cnt), 64'h0);

        reset = 1'b0;
        repeat (20) tick();
        check("idle_ready", 64'(ready), 64'h0);
        check("idle_served", 64'(served_cnt), 64'h0);
        req = 4'b0000;

        // Seed 1, warm-up of 8 steps
        seed_in = 64'h1; seed_load = 1'b1;
        tick();
        seed_load = 1'b0;
        check("warm_start_ready", 64'(ready), 64'h0);
        repeat (7) tick();
        check("warm_end_ready", 64'(ready), 64'h0);
        tick();
        check("ready_t9", 64'(ready), 64'h1);
        req = 4'b0100; push(4'b0100, 64'h01B0_0000_0000_0000);
        tick(); req = 4'b0000; tick();
        req = 4'b1000; push(4'b1000, 64'h00D8_0000_0000_0000);
        tick(); req = 4'b0000; tick();
        check("served_2", 64'(served_cnt), 64'd2);

        // Zero seed behaves exactly like seed 1
        seed_in = 64'h0; seed_load = 1'b1;
        tick();
        seed_load = 1'b0;
        check("zs_served_clear", 64'(served_cnt), 64'h0);
        repeat (7) tick();
        check("zs_not_ready", 64'(ready), 64'h0);
        tick();
        check("zs_ready", 64'(ready), 64'h1);
        req = 4'b0100; push(4'b0100, 64'h01B0_0000_0000_0000);
        tick(); req = 4'b0000; tick();
        req = 4'b1000; push(4'b1000, 64'h00D8_0000_0000_0000);
        tick(); req = 4'b0000; tick();
        check("zs_served_2", 64'(served_cnt), 64'd2);

        // Round-robin over all four from ptr=0
        seed_in = 64'h1; seed_load = 1'b1;
        tick();
        seed_load = 1'b0;
        repeat (8) tick();
        check("rr_ready", 64'(ready), 64'h1);
        req = 4'b1111;
        push(4'b0001, 64'h01B0_0000_0000_0000);
        push(4'b0010, 64'h00D8_0000_0000_0000);
        push(4'b0100, 64'h006C_0000_0000_0000);
        push(4'b1000, 64'h0036_0000_0000_0000);
        push(4'b0001, 64'h001B_0000_0000_0000);
        repeat (5) tick();
        req = 4'b0000;
        tick();
        check("rr_served_5", 64'(served_cnt), 64'd5);
        check("rr_done_grant", 64'(grant), 64'h0);

        // Single requester held: self-mask gives alternate-cycle grants
        req = 4'b0010;
        push(4'b0010, 64'h000D_8000_0000_0000);
        push(4'b0010, 64'h0006_C000_0000_0000);
        push(4'b0010, 64'h0003_6000_0000_0000);
        tick();
        tick();
        check("single_gap1", 64'(grant), 64'h0);
        tick();
        tick();
        check("single_gap2", 64'(grant), 64'h0);
        tick();
        req = 4'b0000;
        tick();
        check("single_served_8", 64'(served_cnt), 64'd8);

        // Reseed while serving
        req = 4'b0011; push(4'b0001, 64'h0001_B000_0000_0000);
        tick();
        seed_in = 64'h2; seed_load = 1'b1;
        check("reseed_grant_kept", 64'(grant), 64'h1);
        tick();
        seed_load = 1'b0;
        req = 4'b0010;
        check("reseed_served_clear", 64'(served_cnt), 64'h0);
        check("reseed_no_grant", 64'(grant), 64'h0);
        push(4'b0010, 64'h0360_0000_0000_0000);
        repeat (8) tick();
        check("reseed_ready", 64'(ready), 64'h1);
        check("reseed_still_no_grant", 64'(grant), 64'h0);
        tick();
        req = 4'b0000;
        tick();
        check("reseed_served_1", 64'(served_cnt), 64'd1);

        // Reset while a grant would be issued
        req = 4'b0100; reset = 1'b1;
        tick();
        check("mid_rst_grant", 64'(grant), 64'h0);
        check("mid_rst_valid", 64'(rnd_valid), 64'h0);
        check("mid_rst_ready", 64'(ready), 64'h0);
        check("mid_rst_served", 64'(served_cnt), 64'h0);
        check("mid_rst_data", rnd_data, 64'h0);
        reset = 1'b0;
        repeat (5) tick();
        req = 4'b0000;
        check("sb_drained", 64'(sb.size()), 64'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
